// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the hellorld UART receiver
package uart_rx_pkg;

  // Receive FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_e;

  // Smallest usable clocks-per-bit; keeps the half-bit count >= 1
  localparam int MIN_DIV   = 4;
  localparam int DATA_BITS = 8;

endpackage

// File: rtl/hellorld_uart_rx_fifo.sv
// rtl/hellorld_uart_rx_fifo.sv - first-word-fall-through byte FIFO for the UART receiver
module hellorld_uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_BITS-1:0]       din,
  output logic                       full,
  input  logic                       pop,
  output logic [DATA_BITS-1:0]       dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic                 w_do_pop;
  logic                 w_do_push;

  // Extra pointer bit distinguishes full from empty
  assign level = r_wr_ptr - r_rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  // A pop frees a slot in the same cycle, so a push while full is accepted alongside it
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Pointer and storage update; storage cleared so the head reads 0 after reset
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= din;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hellorld_uart_rx.sv
// rtl/hellorld_uart_rx.sv - 8N1 serial receiver with sticky error flags and byte FIFO
module hellorld_uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_n,
  input  logic                          rx_i,
  input  logic [DIV_W-1:0]              baud_div,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  input  logic                          clear_i
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_d;
  rx_state_e              r_state;
  logic [DIV_W-1:0]       r_cnt;
  logic [DIV_W-1:0]       r_div;
  logic [BW-1:0]          r_bitidx;
  logic [DATA_BITS-1:0]   r_sr;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic                   w_rxs;
  logic                   w_start_edge;
  logic                   w_tick;
  logic [DIV_W-1:0]       w_div_new;
  logic                   w_push;
  logic                   w_stop_bad;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;

  assign w_rxs        = r_sync[SYNC_STAGES-1];
  assign w_start_edge = !w_rxs && r_rxs_d;
  assign w_tick       = (r_cnt == '0);
  assign w_div_new    = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;

  // Stop-bit decisions are combinational so the byte lands in the FIFO on the tick edge
  assign w_push     = (r_state == STOP) && w_tick && w_rxs;
  assign w_stop_bad = (r_state == STOP) && w_tick && !w_rxs;

  assign valid_o     = !w_empty;
  assign w_pop       = valid_o && ready_i;
  assign busy_o      = (r_state != IDLE);
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

  // Metastability synchronizer plus one delayed copy for start-edge detection
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync  <= SYNC_STAGES'({r_sync, rx_i});
      r_rxs_d <= w_rxs;
    end
  end

  // Receive FSM with bit-timing counter, shift register and sticky framing flag
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_div       <= DIV_W'(MIN_DIV);
      r_bitidx    <= '0;
      r_sr        <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_stop_bad) begin
        r_frame_err <= 1'b1;
      end else if (clear_i) begin
        r_frame_err <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_start_edge) begin
            r_div   <= w_div_new;
            r_cnt   <= (w_div_new >> 1) - DIV_W'(1);
            r_state <= START;
          end
        end
        START: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - DIV_W'(1);
          end else if (w_rxs) begin
            r_state <= IDLE;
          end else begin
            r_cnt    <= r_div - DIV_W'(1);
            r_bitidx <= '0;
            r_state  <= DATA;
          end
        end
        DATA: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - DIV_W'(1);
          end else begin
            r_sr  <= {w_rxs, r_sr[DATA_BITS-1:1]};
            r_cnt <= r_div - DIV_W'(1);
            if (r_bitidx == BIT_LAST) begin
              r_state <= STOP;
            end else begin
              r_bitidx <= r_bitidx + 1'b1;
            end
          end
        end
        STOP: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - DIV_W'(1);
          end else if (w_rxs) begin
            r_state <= IDLE;
          end else begin
            r_state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          // Hold off until the line returns high so a break is not read as 0x00 bytes
          if (w_rxs) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky overrun: a good byte arrived with no room and no simultaneous pop
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overrun <= 1'b1;
    end else if (clear_i) begin
      r_overrun <= 1'b0;
    end
  end

  hellorld_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (r_sr),
    .full  (w_full),
    .pop   (w_pop),
    .dout  (data_o),
    .empty (w_empty),
    .level (level_o)
  );

endmodule

// File: tb/tb_hellorld_uart_rx.sv
// tb/tb_hellorld_uart_rx.sv - directed self-checking bench for hellorld_uart_rx
module tb_hellorld_uart_rx;

  logic        clk_i    = 1'b0;
  logic        rst_n    = 1'b0;
  logic        rx_i     = 1'b1;
  logic [15:0] baud_div = 16'd1040;
  logic        ready_i  = 1'b1;
  logic        clear_i  = 1'b0;
  logic [7:0]  data_o;
  logic        valid_o;
  logic [2:0]  level_o;
  logic        busy_o;
  logic        frame_err_o;
  logic        overrun_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  rx_q[$];

  hellorld_uart_rx #(
    .DIV_W       (16),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .baud_div    (baud_div),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .level_o     (level_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .clear_i     (clear_i)
  );

  always #5 clk_i = ~clk_i;

  // Record every byte handed over (valid & ready) on the falling edge
  always @(negedge clk_i) begin
    if (rst_n && valid_o && ready_i) rx_q.push_back(data_o);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // 8N1 frame: start, 8 data bits LSB first, stop at stop_lvl for stop_bits bit times, then idle high
  task automatic send(input logic [7:0] b, input int bitc, input logic stop_lvl, input int stop_bits);
    rx_i = 1'b0;
    step(bitc);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      step(bitc);
    end
    rx_i = stop_lvl;
    step(bitc * stop_bits);
    rx_i = 1'b1;
  endtask

  task automatic expect_q(input string tag, input logic [7:0] b);
    chk({tag, "_avail"}, 32'(rx_q.size() > 0), 32'd1);
    if (rx_q.size() > 0) chk(tag, 32'(rx_q.pop_front()), 32'(b));
  endtask

  initial begin
    int cnt;

    // Reset values
    step(3);
    chk("rst_data",  32'(data_o),      32'h0);
    chk("rst_valid", 32'(valid_o),     32'h0);
    chk("rst_level", 32'(level_o),     32'h0);
    chk("rst_busy",  32'(busy_o),      32'h0);
    chk("rst_ferr",  32'(frame_err_o), 32'h0);
    chk("rst_ovr",   32'(overrun_o),   32'h0);
    rst_n = 1'b1;
    step(5);

    // Normal byte at 1040 clocks/bit; valid after 9.5*1040 + 2 sync + 1
    cnt = 0;
    fork
      send(8'h48, 1040, 1'b1, 1);
      begin
        while (!valid_o && cnt < 12000) begin
          step(1);
          cnt++;
        end
        chk("lat48",   32'(cnt),         32'd9883);
        chk("data48",  32'(data_o),      32'h48);
        chk("ferr48",  32'(frame_err_o), 32'h0);
      end
    join
    step(5);
    expect_q("q48", 8'h48);

    // Glitch shorter than half a bit
    rx_i = 1'b0;
    step(100);
    chk("gl_busy", 32'(busy_o), 32'h1);
    step(200);
    rx_i = 1'b1;
    step(600);
    chk("gl_idle",  32'(busy_o),      32'h0);
    chk("gl_valid", 32'(valid_o),     32'h0);
    chk("gl_level", 32'(level_o),     32'h0);
    chk("gl_ferr",  32'(frame_err_o), 32'h0);
    chk("gl_ovr",   32'(overrun_o),   32'h0);
    chk("gl_q",     32'(rx_q.size()), 32'd0);

    // Framing error: stop bit held low for two bit times
    baud_div = 16'd16;
    fork
      send(8'h55, 16, 1'b0, 2);
      begin
        step(170);
        chk("fe_flag",  32'(frame_err_o), 32'h1);
        chk("fe_level", 32'(level_o),     32'h0);
        chk("fe_busy",  32'(busy_o),      32'h1);
      end
    join
    step(5);
    chk("fe_idle", 32'(busy_o), 32'h0);
    send(8'h0A, 16, 1'b1, 1);
    step(5);
    expect_q("fe_0a", 8'h0A);
    chk("fe_q", 32'(rx_q.size()), 32'd0);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    chk("fe_clr", 32'(frame_err_o), 32'h0);

    // Overrun: five bytes into a four-entry FIFO with no consumer
    ready_i = 1'b0;
    for (int b = 1; b <= 5; b++) send(8'(b), 16, 1'b1, 1);
    step(5);
    chk("ov_level", 32'(level_o),   32'd4);
    chk("ov_flag",  32'(overrun_o), 32'h1);
    ready_i = 1'b1;
    step(10);
    for (int b = 1; b <= 4; b++) expect_q($sformatf("ov_d%0d", b), 8'(b));
    chk("ov_q",     32'(rx_q.size()), 32'd0);
    chk("ov_empty", 32'(level_o),     32'd0);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    chk("ov_clr", 32'(overrun_o), 32'h0);

    // Same again, with a pop in the fifth byte's push cycle (edge 9.5*16+3 = 155)
    ready_i = 1'b0;
    for (int b = 1; b <= 4; b++) send(8'(b), 16, 1'b1, 1);
    fork
      send(8'h05, 16, 1'b1, 1);
      begin
        step(154);
        ready_i = 1'b1;
        step(1);
        ready_i = 1'b0;
      end
    join
    step(5);
    chk("np_ovr",   32'(overrun_o), 32'h0);
    chk("np_level", 32'(level_o),   32'd4);
    ready_i = 1'b1;
    step(10);
    for (int b = 1; b <= 5; b++) expect_q($sformatf("np_d%0d", b), 8'(b));

    // Asynchronous reset in the middle of DATA with a byte already queued
    ready_i = 1'b0;
    send(8'h33, 16, 1'b1, 1);
    step(3);
    chk("rs_pre", 32'(valid_o), 32'h1);
    fork
      send(8'h77, 16, 1'b1, 1);
      begin
        step(60);
        rst_n = 1'b0;
        #1;
        chk("rs_data",  32'(data_o),      32'h0);
        chk("rs_valid", 32'(valid_o),     32'h0);
        chk("rs_level", 32'(level_o),     32'h0);
        chk("rs_busy",  32'(busy_o),      32'h0);
        chk("rs_ferr",  32'(frame_err_o), 32'h0);
        chk("rs_ovr",   32'(overrun_o),   32'h0);
      end
    join
    step(5);
    rst_n = 1'b1;
    step(20);
    ready_i = 1'b1;
    rx_q.delete();
    send(8'hA5, 16, 1'b1, 1);
    step(5);
    expect_q("rs_a5", 8'hA5);
    chk("rs_q", 32'(rx_q.size()), 32'd0);

    // Clear coinciding with a bad stop bit: the set wins
    fork
      send(8'h3C, 16, 1'b0, 1);
      begin
        step(154);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
      end
    join
    step(3);
    chk("cs_ferr", 32'(frame_err_o), 32'h1);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    chk("cs_clr", 32'(frame_err_o), 32'h0);
    chk("cs_q",   32'(rx_q.size()), 32'd0);

    // Divider below minimum is clamped to 4; back-to-back frames
    baud_div = 16'd2;
    send(8'hFF, 4, 1'b1, 1);
    send(8'h00, 4, 1'b1, 1);
    step(10);
    expect_q("md_ff", 8'hFF);
    expect_q("md_00", 8'h00);
    chk("md_ferr", 32'(frame_err_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
